// File: rtl/crc_check.sv
// crc_check: receive-side DSI payload CRC checker; recomputes the generator CRC over the
// payload bytes and compares it with the trailing little-endian 16-bit checksum.
module crc_check #(
  parameter int          FRAME_LENGTH = 4,
  parameter logic [15:0] CRC_POLY     = 16'hCAFE,
  parameter logic [15:0] CRC_INIT     = 16'h0000
) (
  input  logic        dsi_clk_i,
  input  logic        dsi_rst_n_i,
  input  logic        rx_valid_i,
  input  logic        rx_start_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        busy_o,
  output logic [15:0] crc_calc_o,
  output logic [15:0] crc_rx_o,
  output logic        crc_done_o,
  output logic        crc_ok_o,
  output logic        crc_err_o
);
  localparam int PAYLOAD_BYTES = FRAME_LENGTH * 3;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI, RESULT} state_t;
  state_t state_q, state_d;
  logic [15:0] crc_q, crc_d, rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc;
  function automatic logic [15:0] step8(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ b[i]) ? ({r[14:0], 1'b1} ^ CRC_POLY) : {r[14:0], 1'b0};
    return r;
  endfunction
  assign acc = rx_valid_i && rx_ready_o;
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    // rx_start always wins: it restarts a packet from any accepting state
    if (acc && rx_start_i) begin
      crc_d   = step8(CRC_INIT, rx_data_i);
      rx_d    = '0;
      cnt_d   = CW'(1);
      state_d = (PAYLOAD_BYTES == 1) ? CRC_LO : PAYLOAD;
    end else if (acc && state_q == PAYLOAD) begin
      crc_d   = step8(crc_q, rx_data_i);
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_d == CW'(PAYLOAD_BYTES)) ? CRC_LO : PAYLOAD;
    end else if (acc && state_q == CRC_LO) begin
      rx_d    = {rx_q[15:8], rx_data_i};
      state_d = CRC_HI;
    end else if (acc && state_q == CRC_HI) begin
      rx_d    = {rx_data_i, rx_q[7:0]};
      state_d = RESULT;
    end else if (state_q == RESULT) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge dsi_clk_i or negedge dsi_rst_n_i) begin
    if (!dsi_rst_n_i) begin
      state_q <= IDLE;
      crc_q   <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
    end
  end
  assign rx_ready_o = state_q != RESULT;
  assign busy_o     = state_q == PAYLOAD || state_q == CRC_LO || state_q == CRC_HI;
  assign crc_calc_o = crc_q;
  assign crc_rx_o   = rx_q;
  assign crc_done_o = state_q == RESULT;
  assign crc_ok_o   = crc_done_o && crc_q == rx_q;
  assign crc_err_o  = crc_done_o && crc_q != rx_q;
endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: drives two checkers (FRAME_LENGTH 1 and 4) from one stream and compares them with a reference CRC model.
module tb_crc_check;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst_n = 0, rx_valid = 0, rx_start = 0, sel = 0;
  logic [7:0] rx_data = 0;
  logic rdy1, busy1, done1, ok1, err1, rdy4, busy4, done4, ok4, err4;
  logic [15:0] calc1, crx1, calc4, crx4;
  logic rdy, busy, done, ok, err;
  logic [15:0] calc, crx;
  int n_chk = 0, n_fail = 0, dones = 0;
  always #5 clk = ~clk;
  crc_check #(.FRAME_LENGTH(1)) u1 (.dsi_clk_i(clk), .dsi_rst_n_i(rst_n), .rx_valid_i(rx_valid),
    .rx_start_i(rx_start), .rx_data_i(rx_data), .rx_ready_o(rdy1), .busy_o(busy1), .crc_calc_o(calc1),
    .crc_rx_o(crx1), .crc_done_o(done1), .crc_ok_o(ok1), .crc_err_o(err1));
  crc_check #(.FRAME_LENGTH(4)) u4 (.dsi_clk_i(clk), .dsi_rst_n_i(rst_n), .rx_valid_i(rx_valid),
    .rx_start_i(rx_start), .rx_data_i(rx_data), .rx_ready_o(rdy4), .busy_o(busy4), .crc_calc_o(calc4),
    .crc_rx_o(crx4), .crc_done_o(done4), .crc_ok_o(ok4), .crc_err_o(err4));
  assign rdy  = sel ? rdy4 : rdy1;
  assign busy = sel ? busy4 : busy1;
  assign done = sel ? done4 : done1;
  assign ok   = sel ? ok4 : ok1;
  assign err  = sel ? err4 : err1;
  assign calc = sel ? calc4 : calc1;
  assign crx  = sel ? crx4 : crx1;
  // Reference: the payload treated as one MSB-first bit string fed through the LFSR rule
  function automatic logic [15:0] model(input bq_t p);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    foreach (p[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ p[i][b];
        c = {c[14:0], fb} ^ (fb ? 16'hCAFE : 16'h0000);
      end
    return c;
  endfunction
  task automatic put(input logic [7:0] d, input logic s);
    rx_valid = 1; rx_start = s; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 0; rx_start = 0;
    if (done) dones++;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; if (done) dones++; end
  endtask
  task automatic send_pkt(input bq_t p, input logic [15:0] c, input bit gaps);
    foreach (p[i]) begin
      if (gaps && $urandom_range(1)) idle($urandom_range(3, 1));
      put(p[i], i == 0);
    end
    if (gaps) idle($urandom_range(2));
    put(c[7:0], 0);
    if (gaps) idle($urandom_range(2));
    put(c[15:8], 0);
  endtask
  function automatic bq_t rand_pl(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction
  task automatic test_reset;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      n_chk++; if (rdy !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ctl sel=%0d rdy=%b busy=%b want 1/0", s, rdy, busy); end
      n_chk++; if (calc !== 16'h0 || crx !== 16'h0) begin n_fail++; $display("FAIL reset_crc sel=%0d calc=%h rx=%h want 0/0", s, calc, crx); end
      n_chk++; if ({done, ok, err} !== 3'b000) begin n_fail++; $display("FAIL reset_res sel=%0d d/o/e=%b want 000", s, {done, ok, err}); end
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_known_ok;
    sel = 0;
    put(8'h00, 1); put(8'h00, 0); put(8'h01, 0);
    n_chk++; if (calc !== 16'hCAFF || busy !== 1'b1) begin n_fail++; $display("FAIL known_calc got %h busy=%b want CAFF 1", calc, busy); end
    put(8'hFF, 0);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL known_early_done got %b want 0", done); end
    put(8'hCA, 0);
    n_chk++; if ({done, ok, err, rdy} !== 4'b1100) begin n_fail++; $display("FAIL known_ok d/o/e/rdy=%b want 1100", {done, ok, err, rdy}); end
    n_chk++; if (crx !== 16'hCAFF) begin n_fail++; $display("FAIL known_rx got %h want CAFF", crx); end
    idle(1);
    n_chk++; if ({done, rdy, busy} !== 3'b010 || calc !== 16'hCAFF) begin n_fail++; $display("FAIL known_after d/rdy/busy=%b calc=%h want 010 CAFF", {done, rdy, busy}, calc); end
  endtask
  task automatic test_known_err;
    sel = 0;
    send_pkt('{8'h00, 8'h00, 8'h01}, 16'hCAFE, 0);
    n_chk++; if ({done, ok, err} !== 3'b101 || crx !== 16'hCAFE) begin n_fail++; $display("FAIL known_err d/o/e=%b rx=%h want 101 CAFE", {done, ok, err}, crx); end
    idle(1);
  endtask
  task automatic test_zero_gaps;
    bq_t z;
    sel = 1;
    for (int i = 0; i < 12; i++) z.push_back(8'h00);
    for (int g = 0; g < 4; g++) begin
      send_pkt(z, 16'h0000, g != 0);
      n_chk++; if ({done, ok, err} !== 3'b110 || calc !== 16'h0) begin n_fail++; $display("FAIL zero_pkt gaps=%0d d/o/e=%b calc=%h want 110 0000", g, {done, ok, err}, calc); end
      idle(1);
    end
  endtask
  task automatic test_restart;
    bq_t a, b;
    logic [15:0] cb;
    sel = 1;
    a = rand_pl(5); b = rand_pl(12); cb = model(b);
    dones = 0;
    foreach (a[i]) put(a[i], i == 0);
    send_pkt(b, cb, 1);
    n_chk++; if (dones !== 1 || ok !== 1'b1 || calc !== cb) begin n_fail++; $display("FAIL restart_payload dones=%0d ok=%b calc=%h want 1 1 %h", dones, ok, calc, cb); end
    idle(1);
    dones = 0;
    foreach (a[i]) put(a[i], i == 0);
    for (int i = 5; i < 12; i++) put(8'h5A, 0);
    put(8'h34, 0);
    put(8'h12, 1);
    n_chk++; if (dones !== 0 || busy !== 1'b1 || crx !== 16'h0) begin n_fail++; $display("FAIL restart_crclo dones=%0d busy=%b rx=%h want 0 1 0000", dones, busy, crx); end
    b = rand_pl(11); b.push_front(8'h12); cb = model(b);
    for (int i = 1; i < 12; i++) put(b[i], 0);
    put(cb[7:0], 0); put(cb[15:8], 0);
    n_chk++; if (dones !== 1 || ok !== 1'b1 || calc !== cb) begin n_fail++; $display("FAIL restart_second dones=%0d ok=%b calc=%h want 1 1 %h", dones, ok, calc, cb); end
    idle(1);
  endtask
  task automatic test_reset_mid;
    bq_t p;
    sel = 1;
    p = rand_pl(12);
    dones = 0;
    foreach (p[i]) put(p[i], i == 0);
    put(8'hAB, 0);
    rst_n = 0;
    #1;
    n_chk++; if ({rdy, busy, done, ok, err} !== 5'b10000 || calc !== 16'h0 || crx !== 16'h0) begin n_fail++; $display("FAIL mid_reset rdy/busy/d/o/e=%b calc=%h rx=%h want 10000 0 0", {rdy, busy, done, ok, err}, calc, crx); end
    #2 rst_n = 1;
    @(posedge clk); #1;
    put(8'h77, 0);
    idle(2);
    n_chk++; if (busy !== 1'b0 || calc !== 16'h0 || dones !== 0) begin n_fail++; $display("FAIL mid_ignore busy=%b calc=%h dones=%0d want 0 0 0", busy, calc, dones); end
  endtask
  task automatic test_random;
    bq_t p;
    logic [15:0] c;
    int k;
    sel = 1;
    for (int n = 0; n < 16; n++) begin
      p = rand_pl(12); c = model(p);
      if (n >= 8) begin
        k = $urandom_range(12 * 8 + 15);
        if (k < 96) p[k / 8][k % 8] = ~p[k / 8][k % 8];
        else c[k - 96] = ~c[k - 96];
      end
      send_pkt(p, c, n[0]);
      n_chk++; if ({done, ok, err} !== ((n < 8) ? 3'b110 : 3'b101) || calc !== model(p)) begin n_fail++; $display("FAIL random_pkt n=%0d d/o/e=%b calc=%h want %b %h", n, {done, ok, err}, calc, (n < 8) ? 3'b110 : 3'b101, model(p)); end
      idle(1);
    end
  endtask
  initial begin
    test_reset;
    test_known_ok;
    test_known_err;
    test_zero_gaps;
    test_restart;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
